// File: rtl/hbm_edge_unpack.sv
// hbm_edge_unpack
//   Per-core consumer of the HBM edge-read protocol. Each issued request
//   {mask, source id} is paired in order with its response cacheline and its
//   scaled source value. The masked lanes of that line are then serialized
//   into a one-edge-per-cycle stream for the combine stage.
//
//   Optional feature macro: EDGE_UNPACK_SKIP_SELF_EN
//     When defined, lanes whose destination id equals the source id are
//     dropped from the mask as the line is loaded.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   rd_hbm_edge_mask/_valid       issued request mask, push request FIFO
//   hbm_active_v_id               source vertex of the issued request
//   hbm_active_v_value/_valid     scaled source value, push value FIFO
//   hbm_edge_data/_valid          response cacheline, push data FIFO
//   front_iteration_end/_valid    upstream iteration-end marker
//   front_iteration_id            upstream iteration id
//   combine_stage_full            downstream backpressure
//   stage_full                    request FIFO almost full
//   edge_src_id/dst_id/value      emitted edge
//   edge_valid                    edge strobe
//   iteration_end/_valid          forwarded iteration-end pulse
//   iteration_id                  registered front_iteration_id

// Small in-order FIFO with combinational read of the head entry.
// A push into a full FIFO is dropped; a pop from an empty FIFO is ignored.
module hbm_edge_unpack_fifo #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  pop_data,
    output logic [AWIDTH:0]   level
);
    localparam int DEPTH = 1 << AWIDTH;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push  = push && (level != (AWIDTH+1)'(DEPTH));
    assign do_pop   = pop && (level != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AWIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AWIDTH'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + (AWIDTH+1)'(1);
            end else if (do_pop && !do_push) begin
                level <= level - (AWIDTH+1)'(1);
            end
        end
    end
endmodule

module hbm_edge_unpack #(
    parameter int V_ID_WIDTH      = 20,
    parameter int V_VALUE_WIDTH   = 32,
    parameter int ITERATION_WIDTH = 8,
    parameter int CACHELINE_LEN   = 16,
    parameter int FIFO_AWIDTH     = 4,
    parameter int FULL_MARGIN     = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CACHELINE_LEN-1:0]            rd_hbm_edge_mask,
    input  logic [V_ID_WIDTH-1:0]               hbm_active_v_id,
    input  logic                                rd_hbm_edge_valid,
    input  logic [V_VALUE_WIDTH-1:0]            hbm_active_v_value,
    input  logic                                hbm_active_v_value_valid,
    input  logic [CACHELINE_LEN*V_ID_WIDTH-1:0] hbm_edge_data,
    input  logic                                hbm_edge_data_valid,
    input  logic                                front_iteration_end,
    input  logic                                front_iteration_end_valid,
    input  logic [ITERATION_WIDTH-1:0]          front_iteration_id,
    input  logic                                combine_stage_full,
    output logic                                stage_full,
    output logic [V_ID_WIDTH-1:0]               edge_src_id,
    output logic [V_ID_WIDTH-1:0]               edge_dst_id,
    output logic [V_VALUE_WIDTH-1:0]            edge_value,
    output logic                                edge_valid,
    output logic                                iteration_end,
    output logic                                iteration_end_valid,
    output logic [ITERATION_WIDTH-1:0]          iteration_id
);
    localparam int LINE_WIDTH = CACHELINE_LEN * V_ID_WIDTH;
    localparam int REQ_WIDTH  = CACHELINE_LEN + V_ID_WIDTH;
    localparam int DEPTH      = 1 << FIFO_AWIDTH;
    localparam logic [FIFO_AWIDTH:0] DEPTH_LEVEL = (FIFO_AWIDTH+1)'(DEPTH);
    localparam logic [FIFO_AWIDTH:0] FULL_LEVEL  = (FIFO_AWIDTH+1)'(DEPTH - FULL_MARGIN);

    typedef enum logic {IDLE, SERIAL} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [REQ_WIDTH-1:0]     req_head;
    logic [V_VALUE_WIDTH-1:0] val_head;
    logic [LINE_WIDTH-1:0]    dat_head;
    logic [FIFO_AWIDTH:0]     req_level;
    logic [FIFO_AWIDTH:0]     val_level;
    logic [FIFO_AWIDTH:0]     dat_level;
    logic [FIFO_AWIDTH:0]     req_level_next;
    logic [CACHELINE_LEN-1:0] req_mask;
    logic [V_ID_WIDTH-1:0]    req_src;
    logic [CACHELINE_LEN-1:0] loaded_mask;
    logic [CACHELINE_LEN-1:0] rem_mask;
    logic [LINE_WIDTH-1:0]    line_data;
    logic [V_ID_WIDTH-1:0]    cur_src;
    logic [V_VALUE_WIDTH-1:0] cur_value;
    logic [V_ID_WIDTH-1:0]    emit_dst;
    logic                     all_ready;
    logic                     all_empty;
    logic                     emitting;
    logic                     last_lane;
    logic                     load;
    logic                     end_cond;

    hbm_edge_unpack_fifo #(.WIDTH(REQ_WIDTH), .AWIDTH(FIFO_AWIDTH)) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_hbm_edge_valid),
        .push_data ({rd_hbm_edge_mask, hbm_active_v_id}),
        .pop       (load),
        .pop_data  (req_head),
        .level     (req_level)
    );

    hbm_edge_unpack_fifo #(.WIDTH(V_VALUE_WIDTH), .AWIDTH(FIFO_AWIDTH)) u_val_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (hbm_active_v_value_valid),
        .push_data (hbm_active_v_value),
        .pop       (load),
        .pop_data  (val_head),
        .level     (val_level)
    );

    hbm_edge_unpack_fifo #(.WIDTH(LINE_WIDTH), .AWIDTH(FIFO_AWIDTH)) u_dat_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (hbm_edge_data_valid),
        .push_data (hbm_edge_data),
        .pop       (load),
        .pop_data  (dat_head),
        .level     (dat_level)
    );

    assign req_mask  = req_head[REQ_WIDTH-1 -: CACHELINE_LEN];
    assign req_src   = req_head[V_ID_WIDTH-1:0];
    assign all_ready = (req_level != '0) && (val_level != '0) && (dat_level != '0);
    assign all_empty = (req_level == '0) && (val_level == '0) && (dat_level == '0);

    // Occupancy the request FIFO will have after this edge, so stage_full
    // can be registered without lagging the push that crosses the threshold.
    always_comb begin
        req_level_next = req_level;
        if (rd_hbm_edge_valid && (req_level != DEPTH_LEVEL)) begin
            req_level_next = req_level_next + (FIFO_AWIDTH+1)'(1);
        end
        if (load) begin
            req_level_next = req_level_next - (FIFO_AWIDTH+1)'(1);
        end
    end

    // Mask captured at load; self-loop lanes optionally removed here so the
    // serializer never sees them.
    always_comb begin
        loaded_mask = req_mask;
`ifdef EDGE_UNPACK_SKIP_SELF_EN
        for (int i = 0; i < CACHELINE_LEN; i++) begin
            if (dat_head[i*V_ID_WIDTH +: V_ID_WIDTH] == req_src) begin
                loaded_mask[i] = 1'b0;
            end
        end
`endif
    end

    // Destination of the lowest remaining lane; scanning downward lets the
    // lowest set bit win.
    always_comb begin
        emit_dst = '0;
        for (int i = CACHELINE_LEN - 1; i >= 0; i--) begin
            if (rem_mask[i]) begin
                emit_dst = line_data[i*V_ID_WIDTH +: V_ID_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a load chooses SERIAL only for a non-empty line;
    // otherwise the last emitted lane returns the serializer to IDLE.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = (loaded_mask != '0) ? SERIAL : IDLE;
        end else if (emitting && last_lane) begin
            state_next = IDLE;
        end
    end

    // Control outputs of the FSM. The next line is loaded in the cycle the
    // current one emits its final lane, which keeps back-to-back lines
    // bubble-free.
    always_comb begin
        emitting  = (state == SERIAL) && !combine_stage_full;
        last_lane = (rem_mask != '0) && ((rem_mask & (rem_mask - CACHELINE_LEN'(1))) == '0);
        load      = all_ready && ((state == IDLE) || (emitting && last_lane));
        end_cond  = front_iteration_end && front_iteration_end_valid && all_empty &&
                    (state == IDLE) && !edge_valid;
    end

    // Line registers: reload on load, otherwise retire the lowest lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_mask  <= '0;
            line_data <= '0;
            cur_src   <= '0;
            cur_value <= '0;
        end else if (load) begin
            rem_mask  <= loaded_mask;
            line_data <= dat_head;
            cur_src   <= req_src;
            cur_value <= val_head;
        end else if (emitting) begin
            rem_mask  <= rem_mask & (rem_mask - CACHELINE_LEN'(1));
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_valid          <= 1'b0;
            edge_src_id         <= '0;
            edge_dst_id         <= '0;
            edge_value          <= '0;
            stage_full          <= 1'b0;
            iteration_end       <= 1'b0;
            iteration_end_valid <= 1'b0;
            iteration_id        <= '0;
        end else begin
            edge_valid <= emitting;
            if (emitting) begin
                edge_src_id <= cur_src;
                edge_dst_id <= emit_dst;
                edge_value  <= cur_value;
            end
            stage_full          <= (req_level_next >= FULL_LEVEL);
            iteration_end       <= end_cond;
            iteration_end_valid <= end_cond;
            iteration_id        <= front_iteration_id;
        end
    end
endmodule

// File: tb/tb_hbm_edge_unpack.sv
// tb_hbm_edge_unpack
//   Self-checking bench for hbm_edge_unpack. Expected edges come from a
//   line-level model: every completed request {mask, src, data, value}
//   expands into one edge per set lane in ascending lane order, appended to
//   a queue that the DUT output stream must match exactly.
//   Honours EDGE_UNPACK_SKIP_SELF_EN when the design is built with it.
module tb_hbm_edge_unpack;
    localparam int VW = 20;
    localparam int VV = 32;
    localparam int IW = 8;
    localparam int CL = 16;

    logic               clk;
    logic               rst;
    logic [CL-1:0]      rd_hbm_edge_mask;
    logic [VW-1:0]      hbm_active_v_id;
    logic               rd_hbm_edge_valid;
    logic [VV-1:0]      hbm_active_v_value;
    logic               hbm_active_v_value_valid;
    logic [CL*VW-1:0]   hbm_edge_data;
    logic               hbm_edge_data_valid;
    logic               front_iteration_end;
    logic               front_iteration_end_valid;
    logic [IW-1:0]      front_iteration_id;
    logic               combine_stage_full;
    logic               stage_full;
    logic [VW-1:0]      edge_src_id;
    logic [VW-1:0]      edge_dst_id;
    logic [VV-1:0]      edge_value;
    logic               edge_valid;
    logic               iteration_end;
    logic               iteration_end_valid;
    logic [IW-1:0]      iteration_id;

    typedef struct {
        logic [VW-1:0] src;
        logic [VW-1:0] dst;
        logic [VV-1:0] val;
    } edge_t;

    edge_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    hbm_edge_unpack dut (
        .clk                       (clk),
        .rst                       (rst),
        .rd_hbm_edge_mask          (rd_hbm_edge_mask),
        .hbm_active_v_id           (hbm_active_v_id),
        .rd_hbm_edge_valid         (rd_hbm_edge_valid),
        .hbm_active_v_value        (hbm_active_v_value),
        .hbm_active_v_value_valid  (hbm_active_v_value_valid),
        .hbm_edge_data             (hbm_edge_data),
        .hbm_edge_data_valid       (hbm_edge_data_valid),
        .front_iteration_end       (front_iteration_end),
        .front_iteration_end_valid (front_iteration_end_valid),
        .front_iteration_id        (front_iteration_id),
        .combine_stage_full        (combine_stage_full),
        .stage_full                (stage_full),
        .edge_src_id               (edge_src_id),
        .edge_dst_id               (edge_dst_id),
        .edge_value                (edge_value),
        .edge_valid                (edge_valid),
        .iteration_end             (iteration_end),
        .iteration_end_valid       (iteration_end_valid),
        .iteration_id              (iteration_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expand one completed request into its expected edges.
    function automatic void add_line(input logic [CL-1:0] mask, input logic [VW-1:0] src,
                                     input logic [CL*VW-1:0] data, input logic [VV-1:0] value);
        edge_t e;
        for (int i = 0; i < CL; i++) begin
            if (mask[i]) begin
                e.src = src;
                e.dst = data[i*VW +: VW];
                e.val = value;
`ifdef EDGE_UNPACK_SKIP_SELF_EN
                if (e.dst != src) exp_q.push_back(e);
`else
                exp_q.push_back(e);
`endif
            end
        end
    endfunction

    function automatic logic [CL*VW-1:0] rand_line();
        logic [CL*VW-1:0] r;
        for (int i = 0; i < CL; i++) r[i*VW +: VW] = VW'($urandom);
        return r;
    endfunction

    task automatic clear_inputs();
        rd_hbm_edge_mask          = '0;
        hbm_active_v_id           = '0;
        rd_hbm_edge_valid         = 1'b0;
        hbm_active_v_value        = '0;
        hbm_active_v_value_valid  = 1'b0;
        hbm_edge_data             = '0;
        hbm_edge_data_valid       = 1'b0;
        front_iteration_end       = 1'b0;
        front_iteration_end_valid = 1'b0;
        front_iteration_id        = '0;
        combine_stage_full        = 1'b0;
    endtask

    task automatic push_line(input logic [CL-1:0] mask, input logic [VW-1:0] src,
                             input logic [CL*VW-1:0] data, input logic [VV-1:0] value);
        rd_hbm_edge_mask         = mask;
        hbm_active_v_id          = src;
        rd_hbm_edge_valid        = 1'b1;
        hbm_edge_data            = data;
        hbm_edge_data_valid      = 1'b1;
        hbm_active_v_value       = value;
        hbm_active_v_value_valid = 1'b1;
    endtask

    task automatic drop_valids();
        rd_hbm_edge_valid        = 1'b0;
        hbm_edge_data_valid      = 1'b0;
        hbm_active_v_value_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({edge_valid, stage_full, iteration_end, iteration_end_valid} !== 4'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 0000",
                     {edge_valid, stage_full, iteration_end, iteration_end_valid});
        end
        checks++;
        if ({edge_src_id, edge_dst_id, edge_value, iteration_id} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h/%h/%h/%h expected zeros",
                     edge_src_id, edge_dst_id, edge_value, iteration_id);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [CL*VW-1:0] line;
        line = rand_line();
        line[1*VW +: VW] = 20'h00011;
        line[2*VW +: VW] = 20'h00022;
        push_line(16'h0006, 20'h00005, line, 32'h3F000000);
        @(negedge clk);
        drop_valids();
        checks++;
        if (edge_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_early0: got edge_valid=%b expected 0", edge_valid);
        end
        @(negedge clk);
        checks++;
        if (edge_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_early1: got edge_valid=%b expected 0", edge_valid);
        end
        @(negedge clk);
        checks++;
        if ({edge_valid, edge_src_id, edge_dst_id, edge_value} !== {1'b1, 20'h00005, 20'h00011, 32'h3F000000}) begin
            failures++;
            $display("[TB] FAIL single_edge0: got v=%b %h %h %h expected v=1 00005 00011 3f000000",
                     edge_valid, edge_src_id, edge_dst_id, edge_value);
        end
        @(negedge clk);
        checks++;
        if ({edge_valid, edge_src_id, edge_dst_id, edge_value} !== {1'b1, 20'h00005, 20'h00022, 32'h3F000000}) begin
            failures++;
            $display("[TB] FAIL single_edge1: got v=%b %h %h %h expected v=1 00005 00022 3f000000",
                     edge_valid, edge_src_id, edge_dst_id, edge_value);
        end
        @(negedge clk);
        checks++;
        if (edge_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_after: got edge_valid=%b expected 0", edge_valid);
        end
    endtask

    task automatic test_zero_mask();
        logic [IW-1:0] id;
        push_line(16'h0000, 20'h00abc, rand_line(), $urandom);
        front_iteration_end       = 1'b1;
        front_iteration_end_valid = 1'b1;
        id = IW'($urandom);
        front_iteration_id = id;
        @(negedge clk);
        drop_valids();
        checks++;
        if (iteration_id !== id) begin
            failures++;
            $display("[TB] FAIL iter_id: got %h expected %h", iteration_id, id);
        end
        @(negedge clk);
        checks++;
        if ({edge_valid, iteration_end} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL zero_busy: got valid/end=%b expected 00", {edge_valid, iteration_end});
        end
        @(negedge clk);
        checks++;
        if ({edge_valid, iteration_end, iteration_end_valid} !== 3'b011) begin
            failures++;
            $display("[TB] FAIL zero_drained: got valid/end/endv=%b expected 011",
                     {edge_valid, iteration_end, iteration_end_valid});
        end
        front_iteration_end       = 1'b0;
        front_iteration_end_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (edge_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL zero_no_edge: got edge_valid=%b expected 0", edge_valid);
            end
        end
    endtask

    task automatic test_stall();
        logic [CL*VW-1:0] line;
        edge_t e;
        int seen;
        int stall_left;
        line = rand_line();
        for (int i = 0; i < CL; i++) line[i*VW + VW - 1] = 1'b0;
        push_line(16'hFFFF, VW'($urandom) | 20'h80000, line, $urandom);
        add_line(16'hFFFF, hbm_active_v_id, line, hbm_active_v_value);
        seen = 0;
        stall_left = 0;
        @(negedge clk);
        drop_valids();
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (stall_left > 0) begin
                checks++;
                if (edge_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stall_quiet: got edge_valid=%b expected 0", edge_valid);
                end
                stall_left--;
                if (stall_left == 0) combine_stage_full = 1'b0;
            end else if (edge_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL stall_extra: got dst %h expected no edge", edge_dst_id);
                end else begin
                    e = exp_q.pop_front();
                    if ({edge_src_id, edge_dst_id, edge_value} !== {e.src, e.dst, e.val}) begin
                        failures++;
                        $display("[TB] FAIL stall_edge%0d: got %h %h %h expected %h %h %h",
                                 seen, edge_src_id, edge_dst_id, edge_value, e.src, e.dst, e.val);
                    end
                end
                seen++;
                if (seen == 5) begin
                    combine_stage_full = 1'b1;
                    stall_left = 3;
                end
            end
        end
        checks++;
        if (seen != 16 || exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL stall_count: got %0d edges expected 16", seen);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [CL*VW-1:0] l1;
        logic [CL*VW-1:0] l2;
        edge_t e;
        int waited;
        l1 = rand_line();
        l2 = rand_line();
        push_line(16'h8001, 20'h00101, l1, 32'h11111111);
        add_line(16'h8001, 20'h00101, l1, 32'h11111111);
        @(negedge clk);
        push_line(16'h0001, 20'h00202, l2, 32'h22222222);
        add_line(16'h0001, 20'h00202, l2, 32'h22222222);
        @(negedge clk);
        drop_valids();
        waited = 0;
        while (edge_valid !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (edge_valid !== 1'b1 || exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL b2b_valid%0d: got edge_valid=%b expected 1", k, edge_valid);
            end else begin
                e = exp_q.pop_front();
                if ({edge_src_id, edge_dst_id, edge_value} !== {e.src, e.dst, e.val}) begin
                    failures++;
                    $display("[TB] FAIL b2b_edge%0d: got %h %h %h expected %h %h %h",
                             k, edge_src_id, edge_dst_id, edge_value, e.src, e.dst, e.val);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (edge_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_after: got edge_valid=%b expected 0", edge_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_stage_full();
        logic [CL-1:0]    masks [12];
        logic [VW-1:0]    srcs  [12];
        logic [CL*VW-1:0] lines [12];
        edge_t e;
        int last_edge;
        int done;
        for (int k = 0; k < 12; k++) begin
            masks[k] = CL'($urandom_range(1, 65535));
            srcs[k]  = VW'($urandom);
            lines[k] = rand_line();
        end
        for (int k = 0; k < 12; k++) begin
            rd_hbm_edge_mask  = masks[k];
            hbm_active_v_id   = srcs[k];
            rd_hbm_edge_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (stage_full !== (k == 11)) begin
                failures++;
                $display("[TB] FAIL stage_full_%0d: got %b expected %b", k + 1, stage_full, k == 11);
            end
        end
        rd_hbm_edge_valid         = 1'b0;
        front_iteration_end       = 1'b1;
        front_iteration_end_valid = 1'b1;
        for (int k = 0; k < 12 + 35; k++) begin
            hbm_edge_data_valid = (k < 12);
            if (k < 12) hbm_edge_data = lines[k];
            @(negedge clk);
            checks++;
            if ({edge_valid, iteration_end} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL wait_value: got valid/end=%b expected 00", {edge_valid, iteration_end});
            end
        end
        hbm_edge_data_valid = 1'b0;
        last_edge = -100;
        done = 0;
        for (int cyc = 0; cyc < 400 && done == 0; cyc++) begin
            @(negedge clk);
            if (edge_valid === 1'b1) begin
                last_edge = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL full_extra: got dst %h expected no edge", edge_dst_id);
                end else begin
                    e = exp_q.pop_front();
                    if ({edge_src_id, edge_dst_id, edge_value} !== {e.src, e.dst, e.val}) begin
                        failures++;
                        $display("[TB] FAIL full_edge: got %h %h %h expected %h %h %h",
                                 edge_src_id, edge_dst_id, edge_value, e.src, e.dst, e.val);
                    end
                end
            end
            if (iteration_end === 1'b1) begin
                done = 1;
                checks++;
                if (exp_q.size() != 0 || cyc != last_edge + 2 || iteration_end_valid !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL iter_end_timing: got cycle %0d (pending %0d) expected cycle %0d",
                             cyc, exp_q.size(), last_edge + 2);
                end
            end
            hbm_active_v_value_valid = (cyc < 12);
            if (cyc < 12) begin
                hbm_active_v_value = $urandom;
                add_line(masks[cyc], srcs[cyc], lines[cyc], hbm_active_v_value);
            end
        end
        checks++;
        if (done == 0) begin
            failures++;
            $display("[TB] FAIL iter_end_timeout: got no pulse expected one");
        end
        clear_inputs();
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [CL-1:0]    masks [$];
        logic [VW-1:0]    srcs  [$];
        logic [CL*VW-1:0] datas [$];
        logic [VV-1:0]    vals  [$];
        logic [CL*VW-1:0] d;
        logic [CL-1:0]    m;
        edge_t e;
        int n_done;
        int quiet;
        n_done = 0;
        quiet  = 0;
        for (int cyc = 0; cyc < 700 && quiet < 6; cyc++) begin
            @(negedge clk);
            if (edge_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rand_extra: got dst %h expected no edge", edge_dst_id);
                end else begin
                    e = exp_q.pop_front();
                    if ({edge_src_id, edge_dst_id, edge_value} !== {e.src, e.dst, e.val}) begin
                        failures++;
                        $display("[TB] FAIL rand_edge: got %h %h %h expected %h %h %h",
                                 edge_src_id, edge_dst_id, edge_value, e.src, e.dst, e.val);
                    end
                end
            end
            drop_valids();
            if (cyc < 400) begin
                combine_stage_full = ($urandom_range(0, 3) == 0);
                if (!stage_full && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 3))
                        0:       m = '0;
                        1:       m = CL'(1) << $urandom_range(0, CL - 1);
                        default: m = CL'($urandom);
                    endcase
                    rd_hbm_edge_mask  = m;
                    hbm_active_v_id   = VW'($urandom);
                    rd_hbm_edge_valid = 1'b1;
                    masks.push_back(m);
                    srcs.push_back(hbm_active_v_id);
                end
            end else begin
                combine_stage_full = 1'b0;
            end
            if (datas.size() < masks.size() && (cyc >= 400 || $urandom_range(0, 2) != 0)) begin
                d = rand_line();
                if ($urandom_range(0, 3) == 0) d[$urandom_range(0, CL - 1)*VW +: VW] = srcs[datas.size()];
                hbm_edge_data       = d;
                hbm_edge_data_valid = 1'b1;
                datas.push_back(d);
            end
            if (vals.size() < masks.size() && (cyc >= 400 || $urandom_range(0, 2) == 0)) begin
                hbm_active_v_value       = $urandom;
                hbm_active_v_value_valid = 1'b1;
                vals.push_back(hbm_active_v_value);
            end
            while (n_done < masks.size() && n_done < datas.size() && n_done < vals.size()) begin
                add_line(masks[n_done], srcs[n_done], datas[n_done], vals[n_done]);
                n_done++;
            end
            if (cyc >= 400 && exp_q.size() == 0 && n_done == masks.size()) quiet++;
        end
        checks++;
        if (exp_q.size() != 0 || n_done != masks.size()) begin
            failures++;
            $display("[TB] FAIL rand_drain: got %0d edges pending expected 0", exp_q.size());
        end
        clear_inputs();
        exp_q.delete();
    endtask

    task automatic test_reset_midline();
        logic [CL*VW-1:0] line;
        logic [CL*VW-1:0] la;
        logic [CL*VW-1:0] lb;
        int waited;
        int seen;
        int expected_n;
        edge_t e;
        line = rand_line();
        push_line(16'hFFFF, 20'h80123, line, 32'h12345678);
        @(negedge clk);
        drop_valids();
        waited = 0;
        while (edge_valid !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({edge_valid, stage_full} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_async: got valid/full=%b expected 00", {edge_valid, stage_full});
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        la = rand_line();
        la[2*VW +: VW] = 20'h12345;
        push_line(16'h0004, 20'h00777, la, 32'h40490FDB);
        add_line(16'h0004, 20'h00777, la, 32'h40490FDB);
        @(negedge clk);
        lb = rand_line();
        lb[4*VW +: VW] = 20'h00999;
        push_line(16'h0010, 20'h00999, lb, 32'hBF800000);
        add_line(16'h0010, 20'h00999, lb, 32'hBF800000);
        @(negedge clk);
        drop_valids();
`ifdef EDGE_UNPACK_SKIP_SELF_EN
        expected_n = 1;
`else
        expected_n = 2;
`endif
        seen = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (edge_valid === 1'b1) begin
                seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL post_reset_extra: got dst %h expected no edge", edge_dst_id);
                end else begin
                    e = exp_q.pop_front();
                    if ({edge_src_id, edge_dst_id, edge_value} !== {e.src, e.dst, e.val}) begin
                        failures++;
                        $display("[TB] FAIL post_reset_edge: got %h %h %h expected %h %h %h",
                                 edge_src_id, edge_dst_id, edge_value, e.src, e.dst, e.val);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (seen != expected_n) begin
            failures++;
            $display("[TB] FAIL post_reset_count: got %0d edges expected %0d", seen, expected_n);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_zero_mask();
        test_stall();
        test_back_to_back();
        test_stage_full();
        test_random();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
